rf_wb_queue: RTL
================

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of queue entries for multi-cycle results; power of two, 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pipe_we  input  1  pipeline writeback request this cycle.
REQ-005 pipe_rd  input  5  pipeline destination register.
REQ-006 pipe_wd  input  32  pipeline writeback data.
REQ-007 mcu_valid  input  1  multi-cycle unit (divider/load miss) result valid.
REQ-008 mcu_rd  input  5  multi-cycle destination register.
REQ-009 mcu_wd  input  32  multi-cycle result data.
REQ-010 mcu_ready  output  1  queue can accept a multi-cycle result.
REQ-011 RFWr  output  1  register-file write enable.
REQ-012 A3  output  5  register-file write address.
REQ-013 WD  output  32  register-file write data.
REQ-014 q_a1, q_a2  input  5 each  decode-stage read addresses for bypass lookup.
REQ-015 hit1, hit2  output  1 each  pending write exists for q_a1 / q_a2.
REQ-016 fwd1, fwd2  output  32 each  bypass data for q_a1 / q_a2; 0 when no hit.
REQ-017 busy  output  1  queue non-empty or RFWr asserted.

Function
REQ-018 RFWr, A3 and WD shall be registered outputs, driving the register file for exactly one cycle per write.
REQ-019 A pipeline request (pipe_we=1, pipe_rd!=0) shall be accepted unconditionally and appear on RFWr/A3/WD on the next cycle (latency 1).
REQ-020 A pipeline request with pipe_rd=0 shall be dropped; RFWr shall not assert for it.
REQ-021 A multi-cycle handshake shall occur when mcu_valid && mcu_ready at a rising edge; the entry {mcu_rd, mcu_wd} shall be pushed into a FIFO of DEPTH entries.
REQ-022 A handshake with mcu_rd=0 shall complete but push nothing.
REQ-023 mcu_ready shall equal !full, registered-count based; no same-cycle pass-through when full, even if a pop occurs that cycle.
REQ-024 Output-port arbitration each cycle: a pipeline request has priority; otherwise, if the FIFO is non-empty, the head shall be popped and presented on the next cycle; otherwise RFWr=0.
REQ-025 The minimum latency from FIFO push to RFWr shall be 1 cycle after the push edge (2 edges total) when no pipeline request competes.
REQ-026 Simultaneous push and pop on a non-full FIFO shall leave the occupancy count unchanged; the read and write pointers shall wrap modulo DEPTH.
REQ-027 Bypass lookup shall be combinational: the youngest matching FIFO entry takes priority, then older FIFO entries, then the registered output stage (RFWr && A3 match); a q_a of 0 shall never hit.
REQ-028 FIFO entries shall be committed in push order; pipeline writes may overtake queued entries (ordering to the same register is the hazard unit's responsibility).
REQ-029 busy shall be (count!=0) || RFWr.

Reset
REQ-030 With rst=1 at a rising edge: count=0, pointers=0, RFWr=0, A3=0, WD=0; mcu_ready=1, hit1=hit2=0 and fwd1=fwd2=0 in the following cycle; queued entries are discarded.
REQ-031 A handshake or pipeline request coincident with rst=1 shall be ignored.

Verification
REQ-032 pipe_we=1, pipe_rd=5, pipe_wd=0x1234 -> next cycle RFWr=1, A3=5, WD=0x1234; the cycle after, RFWr=0.
REQ-033 Push mcu 3/0xAA with pipe idle -> RFWr=1, A3=3, WD=0xAA one cycle later; busy returns to 0 afterwards.
REQ-034 Hold pipe_we=1 (rd=7) for 6 cycles while pushing 4 mcu entries -> mcu_ready=0 after the 4th push; entries drain in order over 4 cycles once the pipeline goes idle.
REQ-035 Queue holds r9=0x11 (older) and r9=0x22 (younger); q_a1=9 -> hit1=1, fwd1=0x22; q_a2=0 -> hit2=0, fwd2=0.
REQ-036 pipe_rd=0 and an mcu handshake with rd=0 -> RFWr never asserts and count stays 0.
REQ-037 Fill the queue to 3 entries, assert rst for one cycle -> count=0, RFWr=0, mcu_ready=1, no stale writes afterwards.

Source files
------------

// File: rtl/rf_wb_queue.sv
// Register-file writeback arbiter with a small FIFO for multi-cycle results.
// Pipeline writebacks always win the single write port; queued multi-cycle
// results drain in push order whenever the pipeline leaves the port idle.
// A combinational bypass lets decode see pending writes before they commit.
module rf_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    input  logic        mcu_valid,
    input  logic [4:0]  mcu_rd,
    input  logic [31:0] mcu_wd,
    output logic        mcu_ready,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] fwd1,
    output logic [31:0] fwd2,
    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [4:0]    r_memRd [DEPTH];
    logic [31:0]   r_memWd [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [CW-1:0] r_count;

    logic          r_rfWr;
    logic [4:0]    r_a3;
    logic [31:0]   r_wd;

    logic          w_full;
    logic          w_empty;
    logic          w_pipeReq;
    logic          w_push;
    logic          w_pop;

    logic [PW-1:0] w_idx;
    logic          w_fifoHit1;
    logic          w_fifoHit2;
    logic          w_hit1;
    logic          w_hit2;
    logic [31:0]   w_fwd1;
    logic [31:0]   w_fwd2;

    // Readiness comes from the registered count only, so a pop in the same
    // cycle never opens a slot early. Register 0 writes are swallowed here.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pipeReq = pipe_we && (pipe_rd != 5'd0);
    assign w_push    = mcu_valid && !w_full && (mcu_rd != 5'd0) && !rst;
    assign w_pop     = !w_pipeReq && !w_empty && !rst;

    // Queue bookkeeping: pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memRd[r_wrPtr] <= mcu_rd;
            r_memWd[r_wrPtr] <= mcu_wd;
        end
    end

    // Write-port stage: pipeline first, then the queue head, else idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rfWr <= 1'b0;
            r_a3   <= '0;
            r_wd   <= '0;
        end else if (w_pipeReq) begin
            r_rfWr <= 1'b1;
            r_a3   <= pipe_rd;
            r_wd   <= pipe_wd;
        end else if (w_pop) begin
            r_rfWr <= 1'b1;
            r_a3   <= r_memRd[r_rdPtr];
            r_wd   <= r_memWd[r_rdPtr];
        end else begin
            r_rfWr <= 1'b0;
        end
    end

    // Bypass search walks oldest to youngest so the youngest match wins;
    // the write-port stage is only consulted when no queued entry matches.
    always_comb begin
        w_idx      = '0;
        w_fifoHit1 = 1'b0;
        w_fifoHit2 = 1'b0;
        w_hit1     = 1'b0;
        w_hit2     = 1'b0;
        w_fwd1     = '0;
        w_fwd2     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rdPtr + PW'(k);
            if (CW'(k) < r_count) begin
                if ((q_a1 != 5'd0) && (r_memRd[w_idx] == q_a1)) begin
                    w_fifoHit1 = 1'b1;
                    w_fwd1     = r_memWd[w_idx];
                end
                if ((q_a2 != 5'd0) && (r_memRd[w_idx] == q_a2)) begin
                    w_fifoHit2 = 1'b1;
                    w_fwd2     = r_memWd[w_idx];
                end
            end
        end
        w_hit1 = w_fifoHit1;
        w_hit2 = w_fifoHit2;
        if (!w_fifoHit1 && r_rfWr && (q_a1 != 5'd0) && (r_a3 == q_a1)) begin
            w_hit1 = 1'b1;
            w_fwd1 = r_wd;
        end
        if (!w_fifoHit2 && r_rfWr && (q_a2 != 5'd0) && (r_a3 == q_a2)) begin
            w_hit2 = 1'b1;
            w_fwd2 = r_wd;
        end
    end

    assign mcu_ready = !w_full;
    assign RFWr      = r_rfWr;
    assign A3        = r_a3;
    assign WD        = r_wd;
    assign hit1      = w_hit1;
    assign hit2      = w_hit2;
    assign fwd1      = w_fwd1;
    assign fwd2      = w_fwd2;
    assign busy      = !w_empty || r_rfWr;

endmodule
